kitchen_timer_ctrl: RTL and testbench

- Countdown controller directly downstream of the push-button debouncers.
- Consumes their one-cycle "just pushed" pulses (minute, second, start/stop) and holds an MM:SS countdown in BCD.
- Decrements the countdown once per internally generated 1 s tick and raises an alarm at 00:00.
- BCD digit outputs feed the seven-segment display driver; `alarm` feeds the buzzer/LED.

---
 rtl/kitchen_timer_ctrl.sv | 169 ++++++++++++++++
 tb/tb_kitchen_timer_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/kitchen_timer_ctrl.sv
// rtl/kitchen_timer_ctrl.sv - MM:SS BCD countdown controller with 1 s prescaler and timed alarm
module kitchen_timer_ctrl #(
    parameter int TICK_DIV   = 100000000,
    parameter int ALARM_SECS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       min_down,
    input  logic       sec_down,
    input  logic       start_down,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       alarm,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_ALARM = 2'b11
    } state_t;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SECS - 1);

    state_t        state_q, state_d;
    logic [3:0]    mt_q, mo_q, st_q, so_q;
    logic [3:0]    mt_d, mo_d, st_d, so_d;
    logic [3:0]    dmt, dmo, dst, dso;
    logic [PW-1:0] presc_q, presc_d;
    logic [AW-1:0] acnt_q, acnt_d;
    logic          counting, tick, any_btn, time_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mt_q    <= 4'd0;
            mo_q    <= 4'd0;
            st_q    <= 4'd0;
            so_q    <= 4'd0;
            presc_q <= '0;
            acnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mt_q    <= mt_d;
            mo_q    <= mo_d;
            st_q    <= st_d;
            so_q    <= so_d;
            presc_q <= presc_d;
            acnt_q  <= acnt_d;
        end
    end

    // One-second decrement of the current time, borrowing seconds then minutes.
    always_comb begin
        dmt = mt_q;
        dmo = mo_q;
        dst = st_q;
        dso = so_q;
        if (so_q != 4'd0) begin
            dso = so_q - 4'd1;
        end else if (st_q != 4'd0) begin
            dst = st_q - 4'd1;
            dso = 4'd9;
        end else begin
            dst = 4'd5;
            dso = 4'd9;
            if (mo_q != 4'd0) begin
                dmo = mo_q - 4'd1;
            end else begin
                dmo = 4'd9;
                dmt = mt_q - 4'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mt_d      = mt_q;
        mo_d      = mo_q;
        st_d      = st_q;
        so_d      = so_q;
        acnt_d    = acnt_q;
        counting  = (state_q == S_RUN) || (state_q == S_ALARM);
        tick      = counting && (presc_q == PRESC_LAST);
        any_btn   = min_down || sec_down || start_down;
        time_zero = ({mt_q, mo_q, st_q, so_q} == 16'h0000);
        if (!counting)
            presc_d = presc_q;
        else if (tick)
            presc_d = '0;
        else
            presc_d = presc_q + PW'(1);

        case (state_q)
            S_IDLE, S_PAUSE: begin
                if (start_down) begin
                    if (!time_zero) begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end
                end else if (min_down && sec_down) begin
                    mt_d = 4'd0;
                    mo_d = 4'd0;
                    st_d = 4'd0;
                    so_d = 4'd0;
                end else if (min_down) begin
                    if (mo_q == 4'd9) begin
                        mo_d = 4'd0;
                        mt_d = (mt_q == 4'd9) ? 4'd0 : mt_q + 4'd1;
                    end else begin
                        mo_d = mo_q + 4'd1;
                    end
                end else if (sec_down) begin
                    if (so_q == 4'd9) begin
                        so_d = 4'd0;
                        st_d = (st_q == 4'd5) ? 4'd0 : st_q + 4'd1;
                    end else begin
                        so_d = so_q + 4'd1;
                    end
                end
            end
            S_RUN: begin
                if (start_down) begin
                    state_d = S_PAUSE;
                end else if (tick) begin
                    mt_d = dmt;
                    mo_d = dmo;
                    st_d = dst;
                    so_d = dso;
                    if ({dmt, dmo, dst, dso} == 16'h0000) begin
                        state_d = S_ALARM;
                        presc_d = '0;
                        acnt_d  = '0;
                    end
                end
            end
            S_ALARM: begin
                if (any_btn) begin
                    state_d = S_IDLE;
                    acnt_d  = '0;
                end else if (tick) begin
                    if (acnt_q == ALARM_LAST) begin
                        state_d = S_IDLE;
                        acnt_d  = '0;
                    end else begin
                        acnt_d = acnt_q + AW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign min_tens = mt_q;
    assign min_ones = mo_q;
    assign sec_tens = st_q;
    assign sec_ones = so_q;
    assign running  = (state_q == S_RUN);
    assign alarm    = (state_q == S_ALARM);
    assign state    = state_q;

endmodule

// File: tb/tb_kitchen_timer_ctrl.sv
// tb/tb_kitchen_timer_ctrl.sv - directed bench for kitchen_timer_ctrl with TICK_DIV=4, ALARM_SECS=3
module tb_kitchen_timer_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       min_down = 1'b0, sec_down = 1'b0, start_down = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, alarm;
    logic [1:0] state;
    logic [15:0] disp;
    int checks = 0;
    int failures = 0;

    assign disp = {min_tens, min_ones, sec_tens, sec_ones};

    kitchen_timer_ctrl #(.TICK_DIV(4), .ALARM_SECS(3)) dut (
        .clk(clk), .rst(rst),
        .min_down(min_down), .sec_down(sec_down), .start_down(start_down),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .running(running), .alarm(alarm), .state(state)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; the pulse is sampled by the next rising edge.
    task automatic pulse(input logic m, input logic s, input logic st);
        min_down = m; sec_down = s; start_down = st;
        @(negedge clk);
        min_down = 1'b0; sec_down = 1'b0; start_down = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (disp !== 16'h0000 || state !== 2'b00 || running !== 1'b0 || alarm !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got disp=%h state=%b run=%b alarm=%b exp 0000/00/0/0", disp, state, running, alarm);
        end
    endtask

    task automatic test_set_and_run();
        do_reset();
        for (int i = 0; i < 3; i++) pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (disp !== 16'h0103 || state !== 2'b00) begin
            failures++;
            $display("FAIL set_0103 got disp=%h state=%b exp 0103/00", disp, state);
        end
        pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (state !== 2'b01 || running !== 1'b1) begin
            failures++;
            $display("FAIL start_run got state=%b run=%b exp 01/1", state, running);
        end
        for (int e = 1; e <= 252; e++) begin
            @(negedge clk);
            if (e == 3) begin
                checks++;
                if (disp !== 16'h0103) begin failures++; $display("FAIL pre_tick got %h exp 0103", disp); end
            end
            if (e == 4) begin
                checks++;
                if (disp !== 16'h0102) begin failures++; $display("FAIL first_tick got %h exp 0102", disp); end
            end
            if (e == 16) begin
                checks++;
                if (disp !== 16'h0059) begin failures++; $display("FAIL minute_borrow got %h exp 0059", disp); end
            end
            if (e == 251) begin
                checks++;
                if (disp !== 16'h0001 || state !== 2'b01) begin
                    failures++;
                    $display("FAIL pre_alarm got disp=%h state=%b exp 0001/01", disp, state);
                end
            end
        end
        checks++;
        if (disp !== 16'h0000 || state !== 2'b11 || alarm !== 1'b1 || running !== 1'b0) begin
            failures++;
            $display("FAIL alarm_entry got disp=%h state=%b alarm=%b run=%b exp 0000/11/1/0", disp, state, alarm, running);
        end
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk);
            if (e == 11) begin
                checks++;
                if (alarm !== 1'b1 || state !== 2'b11) begin
                    failures++;
                    $display("FAIL alarm_hold got alarm=%b state=%b exp 1/11", alarm, state);
                end
            end
        end
        checks++;
        if (state !== 2'b00 || alarm !== 1'b0 || disp !== 16'h0000) begin
            failures++;
            $display("FAIL alarm_timeout got state=%b alarm=%b disp=%h exp 00/0/0000", state, alarm, disp);
        end
    endtask

    task automatic test_pause();
        do_reset();
        for (int i = 0; i < 10; i++) pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (state !== 2'b10 || disp !== 16'h0010 || running !== 1'b0) begin
            failures++;
            $display("FAIL pause_on_tick got state=%b disp=%h run=%b exp 10/0010/0", state, disp, running);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (disp !== 16'h0010 || state !== 2'b10) begin
            failures++;
            $display("FAIL pause_hold got disp=%h state=%b exp 0010/10", disp, state);
        end
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (disp !== 16'h0011) begin failures++; $display("FAIL pause_set got %h exp 0011", disp); end
        pulse(1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        checks++;
        if (disp !== 16'h0011 || state !== 2'b01) begin
            failures++;
            $display("FAIL resume_wait got disp=%h state=%b exp 0011/01", disp, state);
        end
        @(negedge clk);
        checks++;
        if (disp !== 16'h0010) begin failures++; $display("FAIL resume_tick got %h exp 0010", disp); end
    endtask

    task automatic test_wrap_clear();
        do_reset();
        for (int i = 0; i < 99; i++) pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (disp !== 16'h9900) begin failures++; $display("FAIL min_99 got %h exp 9900", disp); end
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (disp !== 16'h0000) begin failures++; $display("FAIL min_wrap got %h exp 0000", disp); end
        for (int i = 0; i < 12; i++) pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 59; i++) pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (disp !== 16'h1259) begin failures++; $display("FAIL sec_59 got %h exp 1259", disp); end
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (disp !== 16'h1200) begin failures++; $display("FAIL sec_wrap got %h exp 1200", disp); end
        for (int i = 0; i < 34; i++) pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b1, 1'b0);
        checks++;
        if (disp !== 16'h0000) begin failures++; $display("FAIL both_clear got %h exp 0000", disp); end
        pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (state !== 2'b00 || disp !== 16'h0000) begin
            failures++;
            $display("FAIL start_at_zero got state=%b disp=%h exp 00/0000", state, disp);
        end
    endtask

    task automatic test_alarm_button();
        do_reset();
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (state !== 2'b11) begin failures++; $display("FAIL alarm_from_0001 got state=%b exp 11", state); end
        repeat (2) @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (state !== 2'b00 || disp !== 16'h0000 || alarm !== 1'b0) begin
            failures++;
            $display("FAIL alarm_button got state=%b disp=%h alarm=%b exp 00/0000/0", state, disp, alarm);
        end
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        repeat (11) @(negedge clk);
        checks++;
        if (state !== 2'b11) begin failures++; $display("FAIL alarm_cnt_cleared got state=%b exp 11", state); end
        @(negedge clk);
        checks++;
        if (state !== 2'b00) begin failures++; $display("FAIL alarm_second_exit got state=%b exp 00", state); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 46; i++) pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (disp !== 16'h0045 || state !== 2'b01) begin
            failures++;
            $display("FAIL run_0045 got disp=%h state=%b exp 0045/01", disp, state);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (disp !== 16'h0000 || state !== 2'b00 || running !== 1'b0 || alarm !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got disp=%h state=%b run=%b alarm=%b exp 0000/00/0/0", disp, state, running, alarm);
        end
        @(negedge clk);
        rst = 1'b0;
        pulse(1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        checks++;
        if (state !== 2'b00 || disp !== 16'h0000) begin
            failures++;
            $display("FAIL post_reset_start got state=%b disp=%h exp 00/0000", state, disp);
        end
    endtask

    initial begin
        test_reset();
        test_set_and_run();
        test_pause();
        test_wrap_clear();
        test_alarm_button();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
